// File: rtl/ysyx_040066_wb_pkg.sv
// ysyx_040066_wb_pkg: memop encodings and queue entry layout shared by the writeback load queue
package ysyx_040066_wb_pkg;
    localparam logic [1:0] MEMOP_B = 2'b00;
    localparam logic [1:0] MEMOP_H = 2'b01;
    localparam logic [1:0] MEMOP_W = 2'b10;
    localparam logic [1:0] MEMOP_D = 2'b11;
    localparam int MEMOP_UNSIGNED = 2;
    localparam int ADDR_LOW_W = 3;

    // control part of a queued instruction; data and next PC live in XLEN-wide arrays
    typedef struct packed {
        logic [4:0]            rd;
        logic                  wen;
        logic                  load;
        logic [2:0]            memop;
        logic [ADDR_LOW_W-1:0] addr_low;
        logic                  error;
        logic                  resp_error;
    } wb_entry_t;
endpackage

// File: rtl/ysyx_040066_load_align.sv
// ysyx_040066_load_align: extracts and extends the addressed byte/half/word of a load response
module ysyx_040066_load_align
    import ysyx_040066_wb_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int AW = $clog2(XLEN / 8)
)(
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      memop,
    input  logic [AW-1:0]   addr_low,
    output logic [XLEN-1:0] result
);
    logic            uns;
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] b_x, h_x, w_x;

    assign uns = memop[MEMOP_UNSIGNED];
    assign b   = 8'(data >> {addr_low, 3'b000});
    assign h   = 16'(data >> {addr_low[AW-1:1], 4'b0000});
    assign b_x = {{(XLEN-8){~uns & b[7]}}, b};
    assign h_x = {{(XLEN-16){~uns & h[15]}}, h};

    // a 32-bit datapath has no word lane to pick, so word loads return the full word
    if (XLEN == 64) begin : g_word
        logic [31:0] w;
        assign w   = 32'(data >> {addr_low[AW-1], 5'b00000});
        assign w_x = {{32{~uns & w[31]}}, w};
    end else begin : g_word
        assign w_x = data;
    end

    // select the lane by access size
    always_comb result = memop[1:0] == MEMOP_B ? b_x :
                         memop[1:0] == MEMOP_H ? h_x :
                         memop[1:0] == MEMOP_W ? w_x : data;
endmodule

// File: rtl/ysyx_040066_wb_load_queue.sv
// ysyx_040066_wb_load_queue: in-order writeback queue that merges in-order load responses
module ysyx_040066_wb_load_queue
    import ysyx_040066_wb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(XLEN / 8)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic            in_load,
    input  logic [2:0]      in_memop,
    input  logic [AW-1:0]   in_addr_low,
    input  logic [XLEN-1:0] in_data,
    input  logic [XLEN-1:0] in_nxtpc,
    input  logic            in_error,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    input  logic            resp_error,
    output logic            wb_valid,
    output logic            wb_wen,
    output logic            wb_error,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] wb_nxtpc,
    output logic            busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = CW + 2;

    wb_entry_t       q       [DEPTH];
    logic [XLEN-1:0] q_data  [DEPTH];
    logic [XLEN-1:0] q_nxtpc [DEPTH];
    logic [DEPTH-1:0] done;
    logic [PW-1:0]   head, tail, resp_ptr, idx;
    logic [CW-1:0]   count, pend_cnt;
    logic [DW-1:0]   drop_cnt, drop_total;
    logic            pending, enq, cap, drop, pop;
    wb_entry_t       h;
    logic [XLEN-1:0] aligned;

    // oldest queued entry still waiting for its load response, plus how many are waiting
    always_comb begin
        resp_ptr = head;
        pending = 1'b0;
        pend_cnt = '0;
        idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && !done[idx]) begin
                resp_ptr = pending ? resp_ptr : idx;
                pending = 1'b1;
                pend_cnt = pend_cnt + 1'b1;
            end
        end
    end

    assign h          = q[head];
    assign in_ready   = count != CW'(DEPTH);
    assign enq        = in_valid && in_ready && !flush;
    assign pop        = count != '0 && done[head] && !flush;
    assign cap        = resp_valid && drop_cnt == '0 && pending && !flush;
    assign drop       = resp_valid && drop_cnt != '0;
    assign drop_total = drop_cnt + DW'(pend_cnt);
    assign busy       = count != '0 || drop_cnt != '0;
    assign wb_valid   = pop;
    assign wb_error   = wb_valid && (h.error || (h.load && h.resp_error));
    assign wb_wen     = wb_valid && h.wen && !wb_error;
    assign wb_rd      = h.rd;
    assign wb_nxtpc   = q_nxtpc[head];
    assign wb_data    = h.load ? aligned : q_data[head];

    ysyx_040066_load_align #(.XLEN(XLEN)) u_align (
        .data    (q_data[head]),
        .memop   (h.memop),
        .addr_low(AW'(h.addr_low)),
        .result  (aligned)
    );

    // pointers, occupancy, completion flags and the count of responses still owed to flushed loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            drop_cnt <= '0;
            done <= '0;
        end else if (flush) begin
            head <= tail;
            count <= '0;
            drop_cnt <= drop_total - DW'(resp_valid && drop_total != '0);
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
                done[tail] <= !in_load;
            end
            if (cap) done[resp_ptr] <= 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + CW'(enq) - CW'(pop);
            drop_cnt <= drop_cnt - DW'(drop);
        end
    end

    // entry payload; a response overwrites the load's data slot since the ALU value is unused
    always_ff @(posedge clk) begin
        if (enq) begin
            q[tail] <= '{rd: in_rd, wen: in_wen, load: in_load, memop: in_memop,
                         addr_low: ADDR_LOW_W'(in_addr_low), error: in_error, resp_error: 1'b0};
            q_data[tail] <= in_data;
            q_nxtpc[tail] <= in_nxtpc;
        end
        if (cap) begin
            q_data[resp_ptr] <= resp_data;
            q[resp_ptr].resp_error <= resp_error;
        end
    end
endmodule

// File: tb/tb_ysyx_040066_wb_load_queue.sv
// tb_ysyx_040066_wb_load_queue: directed and randomized checks against a queue-based reference model
module tb_ysyx_040066_wb_load_queue;
    localparam int DEPTH = 4;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_wen = 0, in_load = 0, in_error = 0;
    logic        resp_valid = 0, resp_error = 0;
    logic [4:0]  in_rd = 0;
    logic [2:0]  in_memop = 0, in_addr_low = 0;
    logic [63:0] in_data = 0, in_nxtpc = 0, resp_data = 0;
    logic        in_ready, wb_valid, wb_wen, wb_error, busy;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data, wb_nxtpc;
    int          checks = 0, failures = 0;

    ysyx_040066_wb_load_queue #(.XLEN(64), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wen(in_wen), .in_load(in_load), .in_memop(in_memop),
        .in_addr_low(in_addr_low), .in_data(in_data), .in_nxtpc(in_nxtpc), .in_error(in_error),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_error(wb_error), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_nxtpc(wb_nxtpc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        bit          wen, load, err, done, rerr;
        logic [2:0]  memop, addr;
        logic [63:0] data, nxtpc;
    } ment_t;

    ment_t       mq[$];
    int          mdrop = 0;
    bit          e_valid, e_wen, e_err, e_ready, e_busy;
    logic [4:0]  e_rd;
    logic [63:0] e_data, e_nxtpc;

    function automatic logic [63:0] ref_load(logic [63:0] d, logic [2:0] op, logic [2:0] a);
        int nb, off;
        logic [63:0] mask, v;
        nb = op[1:0] == 2'd0 ? 1 : op[1:0] == 2'd1 ? 2 : op[1:0] == 2'd2 ? 4 : 8;
        if (nb == 8) return d;
        off = (int'(a) / nb) * nb;
        mask = (64'd1 << (nb * 8)) - 64'd1;
        v = (d >> (off * 8)) & mask;
        if (!op[2] && v[nb*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_expect();
        e_ready = mq.size() < DEPTH;
        e_busy = mq.size() > 0 || mdrop > 0;
        e_valid = mq.size() > 0 && mq[0].done && !flush;
        e_err = 0; e_wen = 0; e_rd = 0; e_data = 0; e_nxtpc = 0;
        if (e_valid) begin
            e_err = mq[0].err || (mq[0].load && mq[0].rerr);
            e_wen = mq[0].wen && !e_err;
            e_rd = mq[0].rd;
            e_data = mq[0].load ? ref_load(mq[0].data, mq[0].memop, mq[0].addr) : mq[0].data;
            e_nxtpc = mq[0].nxtpc;
        end
    endtask

    task automatic model_edge();
        int pend;
        bit ready, popq;
        ment_t t;
        if (flush) begin
            pend = 0;
            foreach (mq[i]) if (mq[i].load && !mq[i].done) pend++;
            mdrop += pend;
            if (resp_valid && mdrop > 0) mdrop--;
            mq.delete();
            return;
        end
        ready = mq.size() < DEPTH;
        popq = mq.size() > 0 && mq[0].done;
        if (resp_valid) begin
            if (mdrop > 0) mdrop--;
            else for (int i = 0; i < mq.size(); i++) if (mq[i].load && !mq[i].done) begin
                t = mq[i]; t.done = 1; t.data = resp_data; t.rerr = resp_error; mq[i] = t;
                break;
            end
        end
        if (in_valid && ready) begin
            t.rd = in_rd; t.wen = in_wen; t.load = in_load; t.err = in_error; t.done = !in_load;
            t.rerr = 0; t.memop = in_memop; t.addr = in_addr_low; t.data = in_data; t.nxtpc = in_nxtpc;
            mq.push_back(t);
        end
        if (popq) void'(mq.pop_front());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; resp_valid = 0; flush = 0; resp_error = 0;
    endtask

    task automatic enq(bit load, logic [4:0] rd, bit wen, logic [2:0] memop, logic [2:0] addr,
                       logic [63:0] data, bit err);
        in_valid = 1; in_load = load; in_rd = rd; in_wen = wen; in_memop = memop;
        in_addr_low = addr; in_data = data; in_error = err; in_nxtpc = {$urandom, $urandom};
    endtask

    task automatic resp(logic [63:0] d, bit err);
        resp_valid = 1; resp_data = d; resp_error = err;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({in_ready, wb_valid, wb_wen, wb_error, busy} !== 5'b10000) begin
            failures++; $display("FAIL reset_hold: got %b want 10000", {in_ready, wb_valid, wb_wen, wb_error, busy});
        end
        rst_n = 1;
        @(negedge clk); #1;
        checks++;
        if ({in_ready, wb_valid, wb_wen, wb_error, busy} !== 5'b10000) begin
            failures++; $display("FAIL reset_release: got %b want 10000", {in_ready, wb_valid, wb_wen, wb_error, busy});
        end
    endtask

    task automatic test_alu();
        enq(0, 5, 1, 0, 0, 64'h1234, 0); #1;
        checks++;
        if ({wb_valid, in_ready, busy} !== 3'b010) begin
            failures++; $display("FAIL alu_enq_cycle: got %b want 010", {wb_valid, in_ready, busy});
        end
        tick(); #1;
        checks++;
        if ({wb_valid, wb_wen, wb_error, wb_rd, wb_data} !== {3'b110, 5'd5, 64'h1234}) begin
            failures++; $display("FAIL alu_retire: got %h want %h", {wb_valid, wb_wen, wb_error, wb_rd, wb_data}, {3'b110, 5'd5, 64'h1234});
        end
        tick(); #1;
        checks++;
        if ({wb_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL alu_drained: got %b want 00", {wb_valid, busy});
        end
    endtask

    task automatic test_align();
        logic [63:0] want [2];
        want[0] = 64'hFFFF_FFFF_FFFF_FF80;
        want[1] = 64'h0000_0000_0000_0080;
        for (int k = 0; k < 2; k++) begin
            enq(1, 7, 1, k == 1 ? 3'b100 : 3'b000, 3, 64'hDEAD, 0);
            tick();
            resp(64'h0000_0000_8000_0000, 0); #1;
            checks++;
            if (wb_valid !== 1'b0) begin
                failures++; $display("FAIL align_no_bypass%0d: got %b want 0", k, wb_valid);
            end
            tick(); #1;
            checks++;
            if ({wb_valid, wb_wen, wb_rd, wb_data} !== {2'b11, 5'd7, want[k]}) begin
                failures++; $display("FAIL align_data%0d: got %h want %h", k, {wb_valid, wb_wen, wb_rd, wb_data}, {2'b11, 5'd7, want[k]});
            end
            tick();
        end
    endtask

    task automatic test_order();
        enq(1, 1, 1, 3'b011, 0, 0, 0); tick();
        enq(0, 2, 1, 0, 0, 64'hBB, 0); tick();
        enq(1, 3, 1, 3'b011, 0, 0, 0); tick(); #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++; $display("FAIL order_wait_a: got %b want 0", wb_valid);
        end
        resp(64'h11, 0); tick(); #1;
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd1, 64'h11}) begin
            failures++; $display("FAIL order_a: got %h want %h", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd1, 64'h11});
        end
        tick(); #1;
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 64'hBB}) begin
            failures++; $display("FAIL order_b: got %h want %h", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd2, 64'hBB});
        end
        tick(); #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++; $display("FAIL order_wait_c: got %b want 0", wb_valid);
        end
        resp(64'h22, 0); tick(); #1;
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, 64'h22}) begin
            failures++; $display("FAIL order_c: got %h want %h", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd3, 64'h22});
        end
        tick(); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL order_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < DEPTH; k++) begin
            enq(1, 5'(10 + k), 1, 3'b011, 0, 0, 0); #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL full_ready%0d: got %b want 1", k, in_ready);
            end
            tick();
        end
        enq(1, 9, 1, 3'b011, 0, 0, 0);
        resp(64'h55, 0); #1;
        checks++;
        if ({in_ready, wb_valid} !== 2'b00) begin
            failures++; $display("FAIL full_stall: got %b want 00", {in_ready, wb_valid});
        end
        tick(); #1;
        checks++;
        if ({in_ready, wb_valid, wb_rd, wb_data} !== {2'b01, 5'd10, 64'h55}) begin
            failures++; $display("FAIL full_retire: got %h want %h", {in_ready, wb_valid, wb_rd, wb_data}, {2'b01, 5'd10, 64'h55});
        end
        tick(); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL full_reopen: got %b want 1", in_ready);
        end
        for (int k = 1; k < DEPTH; k++) begin
            resp(64'(k), 0);
            tick(); #1;
            checks++;
            if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'(10 + k), 64'(k)}) begin
                failures++; $display("FAIL full_drain%0d: got %h want %h", k, {wb_valid, wb_rd, wb_data}, {1'b1, 5'(10 + k), 64'(k)});
            end
        end
        tick(); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL full_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_flush();
        enq(1, 1, 1, 3'b011, 0, 0, 0); tick();
        enq(1, 2, 1, 3'b011, 0, 0, 0); tick();
        flush = 1; #1;
        checks++;
        if ({wb_valid, busy} !== 2'b01) begin
            failures++; $display("FAIL flush_cycle: got %b want 01", {wb_valid, busy});
        end
        for (int k = 2; k >= 0; k--) begin
            if (k < 2) resp(64'h77, 0);
            tick(); #1;
            checks++;
            if (int'(dut.drop_cnt) != k || wb_valid !== 1'b0 || busy !== (k != 0)) begin
                failures++; $display("FAIL flush_drop%0d: got drop=%0d valid=%b busy=%b want drop=%0d valid=0 busy=%b",
                                     k, dut.drop_cnt, wb_valid, busy, k, k != 0);
            end
        end
        enq(0, 6, 1, 0, 0, 64'h66, 0); tick();
        flush = 1; #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++; $display("FAIL flush_suppress: got %b want 0", wb_valid);
        end
        tick();
        enq(1, 3, 1, 3'b011, 0, 0, 0); tick();
        flush = 1; resp(64'h88, 0);
        tick(); #1;
        checks++;
        if (int'(dut.drop_cnt) != 0 || busy !== 1'b0 || wb_valid !== 1'b0) begin
            failures++; $display("FAIL flush_resp_same: got drop=%0d busy=%b valid=%b want 0 0 0", dut.drop_cnt, busy, wb_valid);
        end
    endtask

    task automatic test_error_reset();
        enq(1, 4, 1, 3'b011, 0, 0, 0); tick();
        resp(64'h99, 1); tick(); #1;
        checks++;
        if ({wb_valid, wb_error, wb_wen} !== 3'b110) begin
            failures++; $display("FAIL resp_error: got %b want 110", {wb_valid, wb_error, wb_wen});
        end
        tick();
        enq(1, 9, 1, 3'b011, 0, 0, 0); tick();
        enq(0, 8, 1, 0, 0, 64'h8, 0); tick(); #1;
        checks++;
        if ({busy, wb_valid} !== 2'b10) begin
            failures++; $display("FAIL midq_busy: got %b want 10", {busy, wb_valid});
        end
        rst_n = 0; #1;
        checks++;
        if ({in_ready, wb_valid, wb_wen, wb_error, busy} !== 5'b10000) begin
            failures++; $display("FAIL reset_async: got %b want 10000", {in_ready, wb_valid, wb_wen, wb_error, busy});
        end
        #1 rst_n = 1;
        mq.delete();
        mdrop = 0;
        @(negedge clk); #1;
        checks++;
        if ({in_ready, wb_valid, busy} !== 3'b100) begin
            failures++; $display("FAIL reset_discard: got %b want 100", {in_ready, wb_valid, busy});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) < 6)
                enq(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)), 3'($urandom),
                    3'($urandom), {$urandom, $urandom}, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) < 5) resp({$urandom, $urandom}, $urandom_range(0, 7) == 0);
            flush = $urandom_range(0, 39) == 0;
            #1;
            model_expect();
            checks++;
            if ({in_ready, busy, wb_valid, wb_wen, wb_error} !== {e_ready, e_busy, e_valid, e_wen, e_err}) begin
                failures++; $display("FAIL rand_ctl@%0d: got %b want %b", n,
                                     {in_ready, busy, wb_valid, wb_wen, wb_error}, {e_ready, e_busy, e_valid, e_wen, e_err});
            end
            if (e_valid) begin
                checks++;
                if ({wb_rd, wb_data, wb_nxtpc} !== {e_rd, e_data, e_nxtpc}) begin
                    failures++; $display("FAIL rand_data@%0d: got %h want %h", n, {wb_rd, wb_data, wb_nxtpc}, {e_rd, e_data, e_nxtpc});
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_align();
        test_order();
        test_full();
        test_flush();
        test_error_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
